spi_cmd_controller: RTL and testbench
=====================================

// Module: spi_cmd_controller
// PURPOSE
//  Frames the byte stream from the SPI slave into register-file transactions for the display controller.
//  Each SS-framed packet starts with a command byte: bit7 = R(1)/W(0), bits6:0 = start address.
//  Following bytes are written to, or read back from, consecutive register addresses.
//  Sits between the SPI slave byte interface and the display register file; supplies the SPI response byte.
// PARAMETERS
//  DEPTH  64  number of implemented registers, 1..128; valid addresses are 0..DEPTH-1
//  AW     7   address width; fixed by the command byte format
// PORTS
//  clk          in   1   system clock; single clock domain
//  rst_n        in   1   asynchronous, active-low reset
//  ss_act       in   1   SS already synchronised and polarity-normalised; 1 = frame active
//  rx_data      in   8   received byte; valid only while rx_valid = 1
//  rx_valid     in   1   single-cycle strobe, one per received byte
//  tx_data      out  8   byte the SPI slave shifts out next; held stable between rx_valid strobes
//  wr_en        out  1   register-file write strobe, single cycle
//  wr_addr      out  AW  write address
//  wr_data      out  8   write data
//  rd_en        out  1   register-file read strobe; rd_data is valid exactly 1 cycle later
//  rd_addr      out  AW  read address
//  rd_data      in   8   read data
//  err_count    out  8   error counter; port exists only when SPI_CMD_ERRCNT_EN is defined
// BEHAVIOUR
//  Reset: state = IDLE; addr = 0; tx_data = 8'h00; wr_en = rd_en = 0; wr_addr = wr_data = rd_addr = 0.
//  Reset is asynchronous and may assert mid-frame; the frame is lost and no partial write is issued.
//  FSM states: IDLE, CMD, WRITE, READ.
//   IDLE -> CMD   on the ss_act rising edge (ss_act registered 1 cycle, compared with current value).
//   CMD, rx_valid, bit7 = 0 -> WRITE; addr <= rx_data[6:0]; tx_data <= 8'h00.
//   CMD, rx_valid, bit7 = 1 -> READ; addr <= rx_data[6:0]; rd_en pulses the next cycle with rd_addr = addr.
//   WRITE, rx_valid: wr_en pulses in the same cycle (combinational from the strobe, registered outputs allowed
//    with 1 cycle latency; the implementation uses 1 cycle); wr_addr = addr; wr_data = rx_data; then addr++.
//   READ: the rd_data captured 1 cycle after rd_en is loaded into tx_data.
//    Each rx_valid in READ increments addr and issues a prefetch rd_en the next cycle.
//    Read data is therefore ready within 3 clk of the byte boundary; clk must be at least 4x sclk.
//   Any state -> IDLE when ss_act = 0, with priority over everything else.
//  Address wrap: the increment wraps DEPTH-1 -> 0 (not 127 -> 0).
//  Out-of-range address (start address >= DEPTH):
//   - writes are dropped, with wr_en held 0;
//   - reads return 8'hFF with rd_en held 0;
//   - auto-increment continues from the start address; from 127 it wraps to 0.
//  rx_valid in the same cycle as the ss_act falling edge: the byte is ignored.
//  rx_valid in the same cycle as the rising edge: the byte is treated as the command byte.
//  rx_valid while IDLE is ignored.
//  wr_en and rd_en are never asserted in the same cycle.
// CONFIGURATION
//  SPI_CMD_ERRCNT_EN defined:
//   - err_count is an 8-bit saturating counter, reset to 0;
//   - it increments once per frame that ends in CMD (no command byte received);
//   - it increments once per out-of-range access byte;
//   - a read of address 7'h7F returns err_count instead of 8'hFF.
//  SPI_CMD_ERRCNT_EN undefined: no counter, no err_count port; 7'h7F behaves as any other address.
// STRUCTURE
//  Package spi_cmd_pkg: state encoding localparams, CMD_RW_BIT = 7, ERRCNT_ADDR = 7'h7F, OOR_READ_VAL = 8'hFF.
//  Sub-module ss_edge_detect: registers ss_act and emits the rise/fall pulses.
//  All remaining logic is flat in spi_cmd_controller.
// TESTING
//  Write burst: ss up; bytes 8'h05, AA, BB, CC -> wr_en x3 at addr 5, 6, 7 with data AA, BB, CC; then ss down.
//  Read burst: reg[10] = 8'h11, reg[11] = 8'h22; bytes 8'h8A, 00, 00 ->
//   - rd_addr 10 then 11;
//   - tx_data = 8'h11 after the cmd byte and 8'h22 after the second byte.
//  Wrap, DEPTH = 64: cmd 8'h3F, then 3 data bytes -> writes to addr 63, 0, 1.
//  Out of range, DEPTH = 64: cmd 8'h50 plus 1 data byte -> no wr_en; cmd 8'hD0 -> tx_data = 8'hFF, no rd_en.
//  Abort: ss drops after 1 data byte of a write burst -> exactly 1 wr_en.
//   Async rst_n mid-frame -> all outputs return to their reset values immediately.
//  ERRCNT_EN: empty frame, plus 1 out-of-range write byte -> err_count = 2; read 8'hFF -> tx_data = 8'h02.
//   Counter preset to 255, then another error -> err_count stays 255.

Source files
------------

// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command controller.
//   - FSM state encoding
//   - command byte layout (read/write flag bit, address width)
//   - special addresses / values used on the read path
//   - address auto-increment helper
package spi_cmd_pkg;

    // Command byte: bit7 selects read (1) or write (0), bits 6:0 carry the start address.
    localparam int CMD_ADDR_W = 7;
    localparam int CMD_RW_BIT = 7;

    // Read of this address returns the error counter when the counter is built in.
    localparam logic [CMD_ADDR_W-1:0] ERRCNT_ADDR = 7'h7F;

    // Value returned for reads of unimplemented addresses.
    localparam logic [7:0] OOR_READ_VAL = 8'hFF;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_CMD_ENC   = 2'd1;
    localparam logic [1:0] ST_WRITE_ENC = 2'd2;
    localparam logic [1:0] ST_READ_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_CMD   = ST_CMD_ENC,
        ST_WRITE = ST_WRITE_ENC,
        ST_READ  = ST_READ_ENC
    } state_t;

    // Where the byte loaded into tx_data comes from once a prefetch completes.
    typedef enum logic [1:0] {
        RD_SRC_RAM = 2'd0,
        RD_SRC_OOR = 2'd1,
        RD_SRC_ERR = 2'd2
    } rd_src_t;

    // Auto-increment: wraps at the last implemented register. Addresses above it
    // (out of range) keep counting and roll over naturally from 127 to 0.
    function automatic logic [CMD_ADDR_W-1:0] addr_inc(
        input logic [CMD_ADDR_W-1:0] a,
        input logic [CMD_ADDR_W-1:0] last_addr
    );
        return (a == last_addr) ? '0 : a + CMD_ADDR_W'(1);
    endfunction

endpackage

// File: rtl/ss_edge_detect.sv
// Slave-select edge detector.
// Registers the (already synchronised, active-high) frame signal and reports
// its rising and falling edges as single-cycle pulses.
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset
//   ss_act  in  frame active (1 = selected)
//   ss_rise out 1-cycle pulse on frame start
//   ss_fall out 1-cycle pulse on frame end
module ss_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic ss_act,
    output logic ss_rise,
    output logic ss_fall
);

    logic ss_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_reg <= 1'b0;
        end else begin
            ss_reg <= ss_act;
        end
    end

    assign ss_rise = ss_act & ~ss_reg;
    assign ss_fall = ~ss_act & ss_reg;

endmodule

// File: rtl/spi_cmd_controller.sv
// SPI command controller.
// Turns the byte stream of an SS-framed SPI packet into register-file
// accesses. The first byte of each frame is a command (bit7 = read, bits 6:0 =
// start address); subsequent bytes are written to, or read back from,
// consecutive addresses. Read data is prefetched so the SPI slave always has
// the next response byte in tx_data.
// Optional feature: define SPI_CMD_ERRCNT_EN to add an 8-bit saturating error
// counter (err_count port, readable at address 7'h7F when out of range).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ss_act              frame active
//   rx_data, rx_valid   received byte and its single-cycle strobe
//   tx_data             next byte to shift out
//   wr_en/addr/data     register-file write port (1-cycle strobe)
//   rd_en/addr, rd_data register-file read port (data 1 cycle after rd_en)
//   err_count           error counter (SPI_CMD_ERRCNT_EN only)
module spi_cmd_controller
    import spi_cmd_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = CMD_ADDR_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ss_act,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic [7:0]    tx_data,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [7:0]    rd_data
`ifdef SPI_CMD_ERRCNT_EN
    ,
    output logic [7:0]    err_count
`endif
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);

    state_t        state_reg, state_next;
    logic          ss_rise, ss_fall;

    logic [AW-1:0] addr_reg;
    logic [7:0]    tx_data_reg;
    logic          wr_en_reg;
    logic [AW-1:0] wr_addr_reg;
    logic [7:0]    wr_data_reg;
    logic          rd_en_reg;
    logic [AW-1:0] rd_addr_reg;

    // Two-stage read pipeline: stage 1 is the cycle rd_en is driven,
    // stage 2 is the cycle rd_data is valid and gets loaded into tx_data.
    logic          fetch_valid_reg, cap_valid_reg;
    rd_src_t       fetch_src_reg, cap_src_reg;

    logic          cmd_strobe, wr_strobe, rd_strobe;
    logic          cmd_is_read;
    logic          fetch_req, fetch_in_range, wr_in_range;
    logic [AW-1:0] addr_next, fetch_addr;
    rd_src_t       fetch_src;
    logic [7:0]    cap_value;

    ss_edge_detect u_ss_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .ss_act  (ss_act),
        .ss_rise (ss_rise),
        .ss_fall (ss_fall)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    assign cmd_is_read = rx_data[CMD_RW_BIT];

    always_comb begin
        state_next = state_reg;
        cmd_strobe = 1'b0;
        wr_strobe  = 1'b0;
        rd_strobe  = 1'b0;
        // Frame end wins over everything, including a byte arriving in the same cycle.
        if (!ss_act) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (ss_rise) begin
                        // A byte arriving together with the frame start is the command.
                        if (rx_valid) begin
                            cmd_strobe = 1'b1;
                            state_next = cmd_is_read ? ST_READ : ST_WRITE;
                        end else begin
                            state_next = ST_CMD;
                        end
                    end
                end
                ST_CMD: begin
                    if (rx_valid) begin
                        cmd_strobe = 1'b1;
                        state_next = cmd_is_read ? ST_READ : ST_WRITE;
                    end
                end
                ST_WRITE: wr_strobe = rx_valid;
                ST_READ:  rd_strobe = rx_valid;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Address / prefetch decode
    // ------------------------------------------------------------------
    always_comb begin
        addr_next      = addr_inc(addr_reg, LAST_ADDR);
        fetch_req      = (cmd_strobe && cmd_is_read) || rd_strobe;
        fetch_addr     = cmd_strobe ? rx_data[AW-1:0] : addr_next;
        fetch_in_range = ({1'b0, fetch_addr} < DEPTH_W);
        wr_in_range    = ({1'b0, addr_reg} < DEPTH_W);
        fetch_src      = RD_SRC_RAM;
        if (!fetch_in_range) begin
            fetch_src = RD_SRC_OOR;
`ifdef SPI_CMD_ERRCNT_EN
            if (fetch_addr == ERRCNT_ADDR) begin
                fetch_src = RD_SRC_ERR;
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg        <= '0;
            tx_data_reg     <= 8'h00;
            wr_en_reg       <= 1'b0;
            wr_addr_reg     <= '0;
            wr_data_reg     <= 8'h00;
            rd_en_reg       <= 1'b0;
            rd_addr_reg     <= '0;
            fetch_valid_reg <= 1'b0;
            fetch_src_reg   <= RD_SRC_RAM;
            cap_valid_reg   <= 1'b0;
            cap_src_reg     <= RD_SRC_RAM;
        end else begin
            wr_en_reg       <= 1'b0;
            rd_en_reg       <= 1'b0;
            fetch_valid_reg <= fetch_req;
            fetch_src_reg   <= fetch_src;
            // A frame that ends mid-prefetch discards the pending response.
            cap_valid_reg   <= fetch_valid_reg && ss_act;
            cap_src_reg     <= fetch_src_reg;

            if (cap_valid_reg && ss_act) begin
                tx_data_reg <= cap_value;
            end

            if (cmd_strobe) begin
                addr_reg <= rx_data[AW-1:0];
                if (!cmd_is_read) begin
                    tx_data_reg <= 8'h00;
                end
            end else if (wr_strobe || rd_strobe) begin
                addr_reg <= addr_next;
            end

            if (fetch_req && fetch_in_range) begin
                rd_en_reg   <= 1'b1;
                rd_addr_reg <= fetch_addr;
            end

            if (wr_strobe && wr_in_range) begin
                wr_en_reg   <= 1'b1;
                wr_addr_reg <= addr_reg;
                wr_data_reg <= rx_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional error counter
    // ------------------------------------------------------------------
`ifdef SPI_CMD_ERRCNT_EN
    logic [7:0] err_count_reg;
    logic       err_event;

    // Errors: a frame closing before any command byte, a data byte written to
    // an unimplemented register, or a prefetch of one (the counter address
    // itself is a legitimate read and is not counted).
    assign err_event = (ss_fall && (state_reg == ST_CMD))
                     || (wr_strobe && !wr_in_range)
                     || (fetch_req && (fetch_src == RD_SRC_OOR));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_reg <= 8'h00;
        end else if (err_event && (err_count_reg != 8'hFF)) begin
            err_count_reg <= err_count_reg + 8'd1;
        end
    end

    assign err_count = err_count_reg;
`else
    logic unused_ss_fall;
    assign unused_ss_fall = ss_fall;
`endif

    always_comb begin
        case (cap_src_reg)
            RD_SRC_RAM: cap_value = rd_data;
`ifdef SPI_CMD_ERRCNT_EN
            RD_SRC_ERR: cap_value = err_count_reg;
`endif
            default:    cap_value = OOR_READ_VAL;
        endcase
    end

    assign tx_data = tx_data_reg;
    assign wr_en   = wr_en_reg;
    assign wr_addr = wr_addr_reg;
    assign wr_data = wr_data_reg;
    assign rd_en   = rd_en_reg;
    assign rd_addr = rd_addr_reg;

endmodule

// File: tb/tb_spi_cmd_controller.sv
// Directed testbench for spi_cmd_controller (DEPTH = 64).
// Models the register file (registered read, 1-cycle latency) and logs every
// write/read strobe; each scenario task checks its own expectations.
module tb_spi_cmd_controller;

    logic       clk;
    logic       rst_n;
    logic       ss_act;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       wr_en;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;
`ifdef SPI_CMD_ERRCNT_EN
    logic [7:0] err_count;
`endif

    int total = 0;
    int bad   = 0;
    int both_cnt = 0;

    logic [7:0] mem [0:127];
    logic [6:0] wa_q [$];
    logic [7:0] wd_q [$];
    logic [6:0] ra_q [$];

    spi_cmd_controller #(.DEPTH(64), .AW(7)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ss_act   (ss_act),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
`ifdef SPI_CMD_ERRCNT_EN
        ,
        .err_count(err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: registered read.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    // Strobe logger, sampled away from the active edge.
    always @(negedge clk) begin
        if (wr_en) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
            mem[wr_addr] = wr_data;
            $display("  wr_en addr=%0d data=%02h", wr_addr, wr_data);
        end
        if (rd_en) begin
            ra_q.push_back(rd_addr);
            $display("  rd_en addr=%0d", rd_addr);
        end
        if (wr_en && rd_en) both_cnt++;
    end

    task automatic clear_logs();
        wa_q.delete();
        wd_q.delete();
        ra_q.delete();
    endtask

    // All tasks start and end at posedge + 1.
    task automatic gap();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic ss_up();
        ss_act = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic ss_down();
        ss_act = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        $display("byte %02h ss=%0b", b, ss_act);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        // rst_n is low here
        total++; if (tx_data !== 8'h00) begin $display("FAIL reset_tx got=%02h exp=00", tx_data); bad++; end
        total++; if (wr_en !== 1'b0) begin $display("FAIL reset_wr_en got=%b exp=0", wr_en); bad++; end
        total++; if (rd_en !== 1'b0) begin $display("FAIL reset_rd_en got=%b exp=0", rd_en); bad++; end
        total++; if (wr_addr !== 7'd0) begin $display("FAIL reset_wr_addr got=%0d exp=0", wr_addr); bad++; end
        total++; if (wr_data !== 8'h00) begin $display("FAIL reset_wr_data got=%02h exp=00", wr_data); bad++; end
        total++; if (rd_addr !== 7'd0) begin $display("FAIL reset_rd_addr got=%0d exp=0", rd_addr); bad++; end
`ifdef SPI_CMD_ERRCNT_EN
        total++; if (err_count !== 8'd0) begin $display("FAIL reset_errcnt got=%0d exp=0", err_count); bad++; end
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        gap();
        total++; if (wr_en !== 1'b0 || rd_en !== 1'b0) begin $display("FAIL idle_strobes got=%b%b exp=00", wr_en, rd_en); bad++; end
    endtask

    task automatic test_write_burst();
        clear_logs();
        ss_up();
        send_byte(8'h05); gap();
        send_byte(8'hAA);
        total++; if (wr_en !== 1'b1 || wr_addr !== 7'd5 || wr_data !== 8'hAA) begin
            $display("FAIL wr_latency got en=%b addr=%0d data=%02h exp en=1 addr=5 data=AA", wr_en, wr_addr, wr_data); bad++; end
        gap();
        send_byte(8'hBB); gap();
        send_byte(8'hCC); gap();
        ss_down();
        total++; if (wa_q.size() != 3) begin $display("FAIL wr_burst_count got=%0d exp=3", wa_q.size()); bad++; end
        else begin
            total++; if (wa_q[0] !== 7'd5 || wd_q[0] !== 8'hAA) begin $display("FAIL wr_burst_0 got=%0d/%02h exp=5/AA", wa_q[0], wd_q[0]); bad++; end
            total++; if (wa_q[1] !== 7'd6 || wd_q[1] !== 8'hBB) begin $display("FAIL wr_burst_1 got=%0d/%02h exp=6/BB", wa_q[1], wd_q[1]); bad++; end
            total++; if (wa_q[2] !== 7'd7 || wd_q[2] !== 8'hCC) begin $display("FAIL wr_burst_2 got=%0d/%02h exp=7/CC", wa_q[2], wd_q[2]); bad++; end
        end
        total++; if (tx_data !== 8'h00) begin $display("FAIL wr_tx got=%02h exp=00", tx_data); bad++; end
    endtask

    task automatic test_read_burst();
        clear_logs();
        mem[10] = 8'h11;
        mem[11] = 8'h22;
        ss_up();
        send_byte(8'h8A);
        total++; if (rd_en !== 1'b1 || rd_addr !== 7'd10) begin $display("FAIL rd_first got en=%b addr=%0d exp en=1 addr=10", rd_en, rd_addr); bad++; end
        gap();
        total++; if (tx_data !== 8'h11) begin $display("FAIL rd_tx0 got=%02h exp=11", tx_data); bad++; end
        send_byte(8'h00);
        total++; if (rd_en !== 1'b1 || rd_addr !== 7'd11) begin $display("FAIL rd_second got en=%b addr=%0d exp en=1 addr=11", rd_en, rd_addr); bad++; end
        gap();
        total++; if (tx_data !== 8'h22) begin $display("FAIL rd_tx1 got=%02h exp=22", tx_data); bad++; end
        send_byte(8'h00); gap();
        ss_down();
        total++; if (ra_q.size() != 3) begin $display("FAIL rd_count got=%0d exp=3", ra_q.size()); bad++; end
        else begin
            total++; if (ra_q[0] !== 7'd10 || ra_q[1] !== 7'd11 || ra_q[2] !== 7'd12) begin
                $display("FAIL rd_addrs got=%0d,%0d,%0d exp=10,11,12", ra_q[0], ra_q[1], ra_q[2]); bad++; end
        end
        total++; if (wa_q.size() != 0) begin $display("FAIL rd_no_write got=%0d exp=0", wa_q.size()); bad++; end
    endtask

    task automatic test_wrap();
        clear_logs();
        ss_up();
        send_byte(8'h3F); gap();
        send_byte(8'h01); gap();
        send_byte(8'h02); gap();
        send_byte(8'h03); gap();
        ss_down();
        total++; if (wa_q.size() != 3) begin $display("FAIL wrap_count got=%0d exp=3", wa_q.size()); bad++; end
        else begin
            total++; if (wa_q[0] !== 7'd63 || wa_q[1] !== 7'd0 || wa_q[2] !== 7'd1) begin
                $display("FAIL wrap_addrs got=%0d,%0d,%0d exp=63,0,1", wa_q[0], wa_q[1], wa_q[2]); bad++; end
            total++; if (wd_q[0] !== 8'h01 || wd_q[1] !== 8'h02 || wd_q[2] !== 8'h03) begin
                $display("FAIL wrap_data got=%02h,%02h,%02h exp=01,02,03", wd_q[0], wd_q[1], wd_q[2]); bad++; end
        end
    endtask

    task automatic test_out_of_range();
        clear_logs();
        ss_up();
        send_byte(8'h50); gap();
        send_byte(8'h5A); gap();
        ss_down();
        total++; if (wa_q.size() != 0) begin $display("FAIL oor_wr got=%0d exp=0", wa_q.size()); bad++; end
        ss_up();
        send_byte(8'hD0);
        total++; if (rd_en !== 1'b0) begin $display("FAIL oor_rd_en got=%b exp=0", rd_en); bad++; end
        gap();
        total++; if (tx_data !== 8'hFF) begin $display("FAIL oor_rd_tx got=%02h exp=FF", tx_data); bad++; end
        send_byte(8'h00); gap();
        total++; if (tx_data !== 8'hFF) begin $display("FAIL oor_rd_tx2 got=%02h exp=FF", tx_data); bad++; end
        ss_down();
        total++; if (ra_q.size() != 0) begin $display("FAIL oor_rd_count got=%0d exp=0", ra_q.size()); bad++; end
        // Start at 127: first byte dropped, address wraps to 0 for the second.
        clear_logs();
        ss_up();
        send_byte(8'h7F); gap();
        send_byte(8'h61); gap();
        send_byte(8'h62); gap();
        ss_down();
        total++; if (wa_q.size() != 1) begin $display("FAIL wrap127_count got=%0d exp=1", wa_q.size()); bad++; end
        else begin
            total++; if (wa_q[0] !== 7'd0 || wd_q[0] !== 8'h62) begin $display("FAIL wrap127 got=%0d/%02h exp=0/62", wa_q[0], wd_q[0]); bad++; end
        end
    endtask

    task automatic test_abort();
        clear_logs();
        ss_up();
        send_byte(8'h20); gap();
        send_byte(8'h77); gap();
        // byte coincides with the frame end: ignored
        ss_act = 1'b0;
        send_byte(8'h88);
        gap();
        // byte while idle: ignored
        send_byte(8'h99); gap();
        total++; if (wa_q.size() != 1) begin $display("FAIL abort_count got=%0d exp=1", wa_q.size()); bad++; end
        else begin
            total++; if (wa_q[0] !== 7'd32 || wd_q[0] !== 8'h77) begin $display("FAIL abort_wr got=%0d/%02h exp=32/77", wa_q[0], wd_q[0]); bad++; end
        end
        // command byte together with the rising edge
        clear_logs();
        ss_act = 1'b1;
        send_byte(8'h30); gap();
        send_byte(8'h44); gap();
        ss_down();
        total++; if (wa_q.size() != 1) begin $display("FAIL rise_cmd_count got=%0d exp=1", wa_q.size()); bad++; end
        else begin
            total++; if (wa_q[0] !== 7'd48 || wd_q[0] !== 8'h44) begin $display("FAIL rise_cmd got=%0d/%02h exp=48/44", wa_q[0], wd_q[0]); bad++; end
        end
    endtask

    task automatic test_async_reset();
        clear_logs();
        ss_up();
        send_byte(8'h21); gap();
        send_byte(8'h5C);
        total++; if (wr_en !== 1'b1) begin $display("FAIL arst_pre got=%b exp=1", wr_en); bad++; end
        #2 rst_n = 1'b0;
        #1;
        total++; if (wr_en !== 1'b0 || rd_en !== 1'b0) begin $display("FAIL arst_strobes got=%b%b exp=00", wr_en, rd_en); bad++; end
        total++; if (wr_addr !== 7'd0 || rd_addr !== 7'd0) begin $display("FAIL arst_addrs got=%0d/%0d exp=0/0", wr_addr, rd_addr); bad++; end
        total++; if (wr_data !== 8'h00 || tx_data !== 8'h00) begin $display("FAIL arst_data got=%02h/%02h exp=00/00", wr_data, tx_data); bad++; end
        ss_act = 1'b0;
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_byte(8'h33); gap();
        total++; if (wa_q.size() != 0) begin $display("FAIL arst_no_write got=%0d exp=0", wa_q.size()); bad++; end
    endtask

`ifdef SPI_CMD_ERRCNT_EN
    task automatic test_errcnt();
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        ss_up();
        ss_down();
        total++; if (err_count !== 8'd1) begin $display("FAIL errcnt_empty got=%0d exp=1", err_count); bad++; end
        ss_up();
        send_byte(8'h50); gap();
        send_byte(8'h12); gap();
        ss_down();
        total++; if (err_count !== 8'd2) begin $display("FAIL errcnt_oor got=%0d exp=2", err_count); bad++; end
        ss_up();
        send_byte(8'hFF); gap();
        total++; if (tx_data !== 8'h02) begin $display("FAIL errcnt_read got=%02h exp=02", tx_data); bad++; end
        ss_down();
        for (int i = 0; i < 253; i++) begin
            ss_up();
            ss_down();
        end
        total++; if (err_count !== 8'd255) begin $display("FAIL errcnt_255 got=%0d exp=255", err_count); bad++; end
        ss_up();
        ss_down();
        total++; if (err_count !== 8'd255) begin $display("FAIL errcnt_sat got=%0d exp=255", err_count); bad++; end
    endtask
`endif

    task automatic test_exclusive();
        total++; if (both_cnt != 0) begin $display("FAIL wr_rd_overlap got=%0d exp=0", both_cnt); bad++; end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        rd_data  = 8'h00;
        rst_n    = 1'b0;
        ss_act   = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #12;
        test_reset();
        test_write_burst();
        test_read_burst();
        test_wrap();
        test_out_of_range();
        test_abort();
        test_async_reset();
`ifdef SPI_CMD_ERRCNT_EN
        test_errcnt();
`endif
        test_exclusive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
